// File: rtl/axi4_lite_slave_regs.sv
// AXI4-Lite slave exposing seven read/write control registers and one read-only status word.
// Write (AW+W -> B) and read (AR -> R) channels run as independent FSMs.
module axi4_lite_slave_regs #(
  parameter logic [31:0] RESET_VALUE = 32'h0000_0000
) (
  input  logic         aclk,
  input  logic         areset,
  input  logic [31:0]  s_awaddr,
  input  logic         s_awvalid,
  output logic         s_awready,
  input  logic [31:0]  s_wdata,
  input  logic [3:0]   s_wstrb,
  input  logic         s_wvalid,
  output logic         s_wready,
  output logic [1:0]   s_bresp,
  output logic         s_bvalid,
  input  logic         s_bready,
  input  logic [31:0]  s_araddr,
  input  logic         s_arvalid,
  output logic         s_arready,
  output logic [31:0]  s_rdata,
  output logic [1:0]   s_rresp,
  output logic         s_rvalid,
  input  logic         s_rready,
  output logic [223:0] ctrl_out,
  input  logic [31:0]  status_in,
  output logic [6:0]   wr_pulse
);
  // state  | meaning
  // W_IDLE | collecting AW and W, in either order
  // W_RESP | write committed, holding B until s_bready
  // R_IDLE | waiting for AR
  // R_DATA | holding R until s_rready

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {W_IDLE, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  w_state_t     w_state;
  r_state_t     r_state;
  logic [223:0] ctrl_q;
  logic         aw_done, w_done;
  logic [31:0]  awaddr_q, wdata_q;
  logic [3:0]   wstrb_q;

  logic         aw_hs, w_hs, ar_hs, commit;
  logic [31:0]  wr_addr, wr_data;
  logic [3:0]   wr_strb;
  logic         wr_ok, rd_ok;
  logic [2:0]   wr_idx, rd_idx;
  logic [31:0]  rd_data;
  logic [1:0]   rd_resp;

  assign aw_hs  = s_awvalid & s_awready;
  assign w_hs   = s_wvalid & s_wready;
  assign ar_hs  = s_arvalid & s_arready;
  assign commit = (w_state == W_IDLE) & (aw_done | aw_hs) & (w_done | w_hs);

  // Whichever half arrives on the commit edge comes straight from the bus.
  assign wr_addr = aw_done ? awaddr_q : s_awaddr;
  assign wr_data = w_done ? wdata_q : s_wdata;
  assign wr_strb = w_done ? wstrb_q : s_wstrb;
  assign wr_idx  = wr_addr[4:2];
  assign wr_ok   = (wr_addr[31:5] == '0) && (wr_addr[1:0] == 2'b00) && (wr_idx != 3'd7);

  assign rd_idx  = s_araddr[4:2];
  assign rd_ok   = (s_araddr[31:5] == '0) && (s_araddr[1:0] == 2'b00);

  assign ctrl_out = ctrl_q;

  always_comb begin
    rd_data = 32'h0;
    rd_resp = RESP_SLVERR;
    if (rd_ok) begin
      rd_resp = RESP_OKAY;
      if (rd_idx == 3'd7)
        rd_data = status_in;
      else
        for (int n = 0; n < 7; n++)
          if (rd_idx == 3'(n)) rd_data = ctrl_q[32*n +: 32];
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      w_state   <= W_IDLE;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      s_awready <= 1'b0;
      s_wready  <= 1'b0;
      s_bvalid  <= 1'b0;
      s_bresp   <= RESP_OKAY;
      wr_pulse  <= '0;
      ctrl_q    <= {7{RESET_VALUE}};
    end else begin
      wr_pulse <= '0;
      case (w_state)
        W_IDLE: begin
          if (commit) begin
            if (wr_ok) begin
              for (int n = 0; n < 7; n++)
                if (wr_idx == 3'(n))
                  for (int b = 0; b < 4; b++)
                    if (wr_strb[b]) ctrl_q[32*n + 8*b +: 8] <= wr_data[8*b +: 8];
              wr_pulse <= 7'(1) << wr_idx;
            end
            s_bresp   <= wr_ok ? RESP_OKAY : RESP_SLVERR;
            s_bvalid  <= 1'b1;
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
            s_awready <= 1'b0;
            s_wready  <= 1'b0;
            w_state   <= W_RESP;
          end else begin
            if (aw_hs) begin
              aw_done  <= 1'b1;
              awaddr_q <= s_awaddr;
            end
            if (w_hs) begin
              w_done  <= 1'b1;
              wdata_q <= s_wdata;
              wstrb_q <= s_wstrb;
            end
            s_awready <= ~(aw_done | aw_hs);
            s_wready  <= ~(w_done | w_hs);
          end
        end
        W_RESP: begin
          if (s_bready) begin
            s_bvalid  <= 1'b0;
            s_awready <= 1'b1;
            s_wready  <= 1'b1;
            w_state   <= W_IDLE;
          end
        end
      endcase
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_state   <= R_IDLE;
      s_arready <= 1'b0;
      s_rvalid  <= 1'b0;
      s_rdata   <= 32'h0;
      s_rresp   <= RESP_OKAY;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (ar_hs) begin
            s_rdata   <= rd_data;
            s_rresp   <= rd_resp;
            s_rvalid  <= 1'b1;
            s_arready <= 1'b0;
            r_state   <= R_DATA;
          end else begin
            s_arready <= 1'b1;
          end
        end
        R_DATA: begin
          if (s_rready) begin
            s_rvalid  <= 1'b0;
            s_arready <= 1'b1;
            r_state   <= R_IDLE;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_axi4_lite_slave_regs.sv
// Scoreboard bench for axi4_lite_slave_regs: expectations are queued when a transaction is
// issued and compared by a negedge monitor when the B/R handshakes and write strobes appear.
module tb_axi4_lite_slave_regs;
  localparam logic [31:0] RV = 32'h0BAD_F00D;

  logic         aclk = 1'b0;
  logic         areset = 1'b1;
  logic [31:0]  s_awaddr = '0;
  logic         s_awvalid = 1'b0;
  logic         s_awready;
  logic [31:0]  s_wdata = '0;
  logic [3:0]   s_wstrb = '0;
  logic         s_wvalid = 1'b0;
  logic         s_wready;
  logic [1:0]   s_bresp;
  logic         s_bvalid;
  logic         s_bready = 1'b0;
  logic [31:0]  s_araddr = '0;
  logic         s_arvalid = 1'b0;
  logic         s_arready;
  logic [31:0]  s_rdata;
  logic [1:0]   s_rresp;
  logic         s_rvalid;
  logic         s_rready = 1'b0;
  logic [223:0] ctrl_out;
  logic [31:0]  status_in = '0;
  logic [6:0]   wr_pulse;

  axi4_lite_slave_regs #(.RESET_VALUE(RV)) dut (
    .aclk(aclk), .areset(areset),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .ctrl_out(ctrl_out), .status_in(status_in), .wr_pulse(wr_pulse)
  );

  always #5 aclk = ~aclk;

  int checks = 0;
  int failures = 0;
  logic [31:0] model [0:6];
  logic [1:0]  bresp_q[$];
  logic [6:0]  pulse_q[$];
  logic [31:0] rdata_q[$];
  logic [1:0]  rresp_q[$];
  bit          prev_bvalid = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  function automatic bit addr_ok(input logic [31:0] a);
    return (a[31:5] == 27'd0) && (a[1:0] == 2'b00);
  endfunction

  function automatic logic [31:0] exp_rd(input logic [31:0] a);
    if (!addr_ok(a)) return 32'h0;
    if (a[4:2] == 3'd7) return status_in;
    return model[a[4:2]];
  endfunction

  task automatic reset_model();
    for (int i = 0; i < 7; i++) model[i] = RV;
  endtask

  task automatic check_ctrl();
    for (int i = 0; i < 7; i++) check_val("ctrl_out", ctrl_out[32*i +: 32], model[i]);
  endtask

  // Monitor: write strobe must coincide with the first B cycle; responses compared on handshake.
  always @(negedge aclk) begin
    if (!areset) begin
      if (s_bvalid && !prev_bvalid) begin
        check_val("pulse_q_size", pulse_q.size(), 1);
        if (pulse_q.size() != 0) check_val("wr_pulse", wr_pulse, pulse_q.pop_front());
      end else if (wr_pulse !== 7'd0) begin
        check_val("pulse_stray", wr_pulse, 0);
      end
      if (s_bvalid && s_bready) begin
        check_val("bresp_q_size", bresp_q.size(), 1);
        if (bresp_q.size() != 0) check_val("bresp", s_bresp, bresp_q.pop_front());
      end
      if (s_rvalid && s_rready) begin
        check_val("rdata_q_size", rdata_q.size(), 1);
        if (rdata_q.size() != 0) begin
          check_val("rdata", s_rdata, rdata_q.pop_front());
          check_val("rresp", s_rresp, rresp_q.pop_front());
        end
      end
    end
    prev_bvalid = s_bvalid;
  end

  // lead > 0: W leads AW by lead cycles; lead < 0: AW leads W.
  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input int lead, input int bdelay);
    logic [1:0] eb;
    logic [6:0] ep;
    bit awd, wd, hs_aw, hs_w;
    int n;
    if (addr_ok(addr) && addr[4:2] != 3'd7) begin
      for (int b = 0; b < 4; b++)
        if (strb[b]) model[addr[4:2]][8*b +: 8] = data[8*b +: 8];
      eb = 2'b00;
      ep = 7'(1) << addr[4:2];
    end else begin
      eb = 2'b10;
      ep = 7'd0;
    end
    bresp_q.push_back(eb);
    pulse_q.push_back(ep);
    s_awaddr = addr; s_wdata = data; s_wstrb = strb;
    s_wvalid = (lead >= 0);
    s_awvalid = (lead <= 0);
    awd = 0; wd = 0; n = 0;
    while (!(awd && wd) && n < 100) begin
      hs_aw = s_awvalid && s_awready;
      hs_w  = s_wvalid && s_wready;
      step();
      n++;
      if (hs_aw) begin awd = 1; s_awvalid = 1'b0; end
      if (hs_w)  begin wd = 1;  s_wvalid = 1'b0; end
      if (!awd && n >= lead)  s_awvalid = 1'b1;
      if (!wd && n >= -lead)  s_wvalid = 1'b1;
      if (wd && !awd) check_val("wready_wait", s_wready, 0);
      if (awd && !wd) check_val("awready_wait", s_awready, 0);
    end
    check_val("aw_w_done", {awd, wd}, 2'b11);
    check_val("bvalid_lat", s_bvalid, 1);
    check_val("awready_resp", s_awready, 0);
    repeat (bdelay) begin
      step();
      check_val("bvalid_hold", s_bvalid, 1);
      check_val("bresp_hold", s_bresp, eb);
      check_val("awready_hold", s_awready, 0);
      check_val("wready_hold", s_wready, 0);
    end
    s_bready = 1'b1;
    step();
    s_bready = 1'b0;
    check_val("bvalid_clr", s_bvalid, 0);
    check_val("awready_back", s_awready, 1);
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [31:0] ed, input logic [1:0] er,
                         input int rdelay);
    bit done, hs;
    int n;
    rdata_q.push_back(ed);
    rresp_q.push_back(er);
    s_araddr = addr;
    s_arvalid = 1'b1;
    done = 0; n = 0;
    while (!done && n < 100) begin
      hs = s_arvalid && s_arready;
      step();
      n++;
      if (hs) begin done = 1; s_arvalid = 1'b0; end
    end
    check_val("ar_done", done, 1);
    status_in = status_in ^ 32'hFFFF_0000;  // data was sampled at AR; later changes must not leak in
    check_val("rvalid_lat", s_rvalid, 1);
    check_val("arready_data", s_arready, 0);
    repeat (rdelay) begin
      step();
      check_val("rdata_hold", s_rdata, ed);
      check_val("rvalid_hold", s_rvalid, 1);
    end
    s_rready = 1'b1;
    step();
    s_rready = 1'b0;
    check_val("rvalid_clr", s_rvalid, 0);
  endtask

  task automatic read_chk(input logic [31:0] addr, input int rdelay);
    do_read(addr, exp_rd(addr), addr_ok(addr) ? 2'b00 : 2'b10, rdelay);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] coll_exp, a, d;
    reset_model();
    repeat (3) step();
    check_val("rst_awready", s_awready, 0);
    check_val("rst_wready", s_wready, 0);
    check_val("rst_arready", s_arready, 0);
    check_val("rst_bvalid", s_bvalid, 0);
    check_val("rst_rvalid", s_rvalid, 0);
    check_val("rst_rdata", s_rdata, 0);
    check_val("rst_wr_pulse", wr_pulse, 0);
    check_ctrl();
    areset = 1'b0;
    step();
    check_val("rel_ready", {s_awready, s_wready, s_arready}, 3'b111);

    do_write(32'h04, 32'hDEAD_BEEF, 4'hF, 0, 0);
    check_val("reg1", ctrl_out[63:32], 32'hDEAD_BEEF);
    do_write(32'h00, 32'hAABB_CCDD, 4'hF, 0, 0);
    do_write(32'h00, 32'h1122_3344, 4'b0101, 3, 0);
    check_val("split_reg0", ctrl_out[31:0], 32'hAA22_CC44);
    do_write(32'h10, 32'h0F0F_0F0F, 4'b1100, -2, 5);
    do_write(32'h14, 32'hFFFF_FFFF, 4'b0000, 0, 0);
    check_ctrl();
    read_chk(32'h04, 3);
    read_chk(32'h00, 0);

    do_write(32'h1C, 32'h1234_5678, 4'hF, 0, 1);
    do_write(32'h20, 32'h1234_5678, 4'hF, 0, 0);
    do_write(32'h06, 32'h1234_5678, 4'hF, 1, 0);
    check_ctrl();
    status_in = 32'h5A5A_0001;
    do_read(32'h1C, 32'h5A5A_0001, 2'b00, 2);
    do_read(32'h40, 32'h0, 2'b10, 1);

    coll_exp = model[2];
    fork
      do_write(32'h08, 32'h1234_5678, 4'hF, 0, 0);
      do_read(32'h08, coll_exp, 2'b00, 0);
    join
    do_read(32'h08, 32'h1234_5678, 2'b00, 0);

    for (int i = 0; i < 24; i++) begin
      int sel;
      sel = $urandom_range(0, 9);
      a = (sel < 8) ? 32'(sel * 4) : ((sel == 8) ? 32'h22 : 32'h1000);
      d = $urandom;
      status_in = $urandom;
      if ($urandom_range(0, 1) == 1)
        do_write(a, d, 4'($urandom_range(0, 15)), $urandom_range(0, 4) - 2, $urandom_range(0, 2));
      else
        read_chk(a, $urandom_range(0, 2));
    end
    check_ctrl();

    // Reset while W is held waiting for AW: the captured half must be dropped.
    s_wdata = 32'hCAFE_F00D; s_wstrb = 4'hF; s_wvalid = 1'b1;
    step();
    s_wvalid = 1'b0;
    check_val("w_captured", s_wready, 0);
    areset = 1'b1;
    step();
    areset = 1'b0;
    reset_model();
    step();
    check_val("w_drop_ready", {s_awready, s_wready}, 2'b11);
    check_ctrl();

    // Reset while in W_RESP with B held off.
    do_write(32'h0C, 32'h7777_8888, 4'hF, 0, 0);
    pulse_q.push_back(7'b000_1000);
    s_awaddr = 32'h0C; s_wdata = 32'h1357_9BDF; s_wstrb = 4'hF;
    s_awvalid = 1'b1; s_wvalid = 1'b1;
    step();
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    check_val("resp_bvalid", s_bvalid, 1);
    check_val("resp_reg3", ctrl_out[127:96], 32'h1357_9BDF);
    step();
    areset = 1'b1;
    step();
    reset_model();
    check_val("mid_rst_bvalid", s_bvalid, 0);
    check_val("mid_rst_ready", {s_awready, s_wready, s_arready}, 3'b000);
    check_ctrl();
    areset = 1'b0;
    step();
    check_val("post_rst_ready", {s_awready, s_wready, s_arready}, 3'b111);
    check_val("post_rst_bvalid", s_bvalid, 0);
    do_write(32'h18, 32'h0000_00A5, 4'b0001, 0, 0);
    read_chk(32'h18, 0);
    read_chk(32'h0C, 0);

    repeat (3) step();
    check_val("bresp_q_left", bresp_q.size(), 0);
    check_val("pulse_q_left", pulse_q.size(), 0);
    check_val("rdata_q_left", rdata_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
